// File: rtl/async_fifo_wptr_full.sv
// Write-side pointer and full-flag generator for an asynchronous FIFO.
//
// Keeps the binary write pointer and drives a registered Gray copy of it
// toward the read domain. The read Gray pointer is brought into this clock
// domain through a plain flop chain. From the synchronized read pointer the
// block derives full, almost-full, fill level and an overflow pulse.
//
// Ports:
//   clk_i          write-domain clock
//   rst_i          asynchronous active-high reset
//   wr_i           push request
//   rptr_gray_i    read Gray pointer (asynchronous to clk_i)
//   wr_en_o        memory write strobe (wr_i & ~full_o), combinational
//   waddr_o        memory write address (low AW bits of the binary pointer)
//   wptr_gray_o    registered Gray write pointer for the read domain
//   full_o         FIFO full, registered
//   almost_full_o  level_o >= AFULL_LEVEL, registered
//   level_o        write-side fill level 0..DEPTH, registered, may overstate
//   ovf_o          one-cycle pulse after a push attempted while full
module async_fifo_wptr_full #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AFULL_LEVEL = DEPTH - 2,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  logic [AW:0]   rptr_gray_i,
  output logic          wr_en_o,
  output logic [AW-1:0] waddr_o,
  output logic [AW:0]   wptr_gray_o,
  output logic          full_o,
  output logic          almost_full_o,
  output logic [AW:0]   level_o,
  output logic          ovf_o
);

  localparam logic [AW:0] AfullLvl = (AW + 1)'(AFULL_LEVEL);

  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wgray_q, wgray_d;
  logic [AW:0] level_q, level_d;
  logic        full_q, full_d;
  logic        afull_q, afull_d;
  logic        ovf_q, ovf_d;
  logic [AW:0] sync_q [SYNC_STAGES];
  logic [AW:0] rq;
  logic [AW:0] rbin_s;
  logic        acc;

  // Read-pointer synchronizer: pure flop chain, nothing in between stages.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rq = sync_q[SYNC_STAGES-1];

  // Gray to binary: bit k is the XOR of all bits at or above k.
  always_comb begin
    rbin_s = '0;
    for (int k = 0; k < AW + 1; k++) begin
      rbin_s[k] = ^(rq >> k);
    end
  end

  assign acc = wr_i & ~full_q;

  always_comb begin
    wbin_d  = wbin_q + {{AW{1'b0}}, acc};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    // Full when the write pointer is exactly one lap ahead: in Gray that is
    // the top two bits inverted and the rest equal.
    full_d  = (wgray_d == {~rq[AW:AW-1], rq[AW-2:0]});
    level_d = wbin_d - rbin_s;
    afull_d = (level_d >= AfullLvl);
    ovf_d   = wr_i & full_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_en_o       = acc;
  assign waddr_o       = wbin_q[AW-1:0];
  assign wptr_gray_o   = wgray_q;
  assign full_o        = full_q;
  assign almost_full_o = afull_q;
  assign level_o       = level_q;
  assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
module tb_async_fifo_wptr_full;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SS    = 2;
  localparam int unsigned AFL   = 6;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          wr_i;
  logic [AW:0]   rptr_gray_i;
  logic          wr_en_o;
  logic [AW-1:0] waddr_o;
  logic [AW:0]   wptr_gray_o;
  logic          full_o;
  logic          almost_full_o;
  logic [AW:0]   level_o;
  logic          ovf_o;

  async_fifo_wptr_full #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SS),
    .AFULL_LEVEL (AFL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .wr_i          (wr_i),
    .rptr_gray_i   (rptr_gray_i),
    .wr_en_o       (wr_en_o),
    .waddr_o       (waddr_o),
    .wptr_gray_o   (wptr_gray_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .level_o       (level_o),
    .ovf_o         (ovf_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counts of accepted pushes and of pops shown on the
  // read pointer, plus a history of read counts to model the sync delay.
  int wcount;
  int rcount;
  bit mfull, mafull, movf;
  int mlevel;
  int hist[$];

  function automatic logic [AW:0] gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wcount = 0;
    rcount = 0;
    mfull  = 0;
    mafull = 0;
    movf   = 0;
    mlevel = 0;
    hist.delete();
  endtask

  task automatic step(input bit w, input int r);
    int seen;
    int occ;
    int prev;
    bit acc;
    wr_i        = w;
    rcount      = r;
    rptr_gray_i = gray(r);
    #1;
    chk("wr_en", 32'(wr_en_o), 32'(w & ~mfull));
    chk("waddr", 32'(waddr_o), 32'(wcount % DEPTH));
    prev = wcount;
    @(posedge clk);
    acc  = w && !mfull;
    movf = w && mfull;
    wcount += int'(acc);
    hist.push_back(r);
    seen = (hist.size() > SS) ? hist[hist.size() - 1 - SS] : 0;
    if (hist.size() > SS + 1) void'(hist.pop_front());
    occ    = wcount - seen;
    mfull  = (occ == DEPTH);
    mafull = (occ >= AFL);
    mlevel = occ;
    #1;
    chk("full", 32'(full_o), 32'(mfull));
    chk("level", 32'(level_o), 32'(mlevel));
    chk("afull", 32'(almost_full_o), 32'(mafull));
    chk("ovf", 32'(ovf_o), 32'(movf));
    chk("wgray", 32'(wptr_gray_o), 32'(gray(wcount)));
    chk("gray_step", 32'($countones(gray(prev) ^ wptr_gray_o) <= 1), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
    chk({tag, "_waddr"}, 32'(waddr_o), 32'd0);
    chk({tag, "_wgray"}, 32'(wptr_gray_o), 32'd0);
    chk({tag, "_full"}, 32'(full_o), 32'd0);
    chk({tag, "_afull"}, 32'(almost_full_o), 32'd0);
    chk({tag, "_level"}, 32'(level_o), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_o), 32'd0);
  endtask

  logic [AW:0] fill_gray [8];

  initial begin
    fill_gray[0] = 4'h1; fill_gray[1] = 4'h3; fill_gray[2] = 4'h2; fill_gray[3] = 4'h6;
    fill_gray[4] = 4'h7; fill_gray[5] = 4'h5; fill_gray[6] = 4'h4; fill_gray[7] = 4'hC;

    // Reset with no clock edge yet.
    model_reset();
    rst_i       = 1'b1;
    wr_i        = 1'b0;
    rptr_gray_i = '0;
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 0);

    // Fill with the read pointer parked at zero.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 0);
      chk("fill_gray", 32'(wptr_gray_o), 32'(fill_gray[i]));
      chk("fill_afull", 32'(almost_full_o), 32'(i >= 5));
    end
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_level", 32'(level_o), 32'd8);

    // Overflow: pushes while full are dropped and flagged.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0);
      chk("ovf_gray", 32'(wptr_gray_o), 32'hC);
      chk("ovf_pulse", 32'(ovf_o), 32'd1);
    end

    // Release: one pop shows up on the third edge.
    step(1'b0, 1);
    chk("rel_e1_full", 32'(full_o), 32'd1);
    step(1'b0, 1);
    chk("rel_e2_full", 32'(full_o), 32'd1);
    step(1'b0, 1);
    chk("rel_e3_full", 32'(full_o), 32'd0);
    chk("rel_e3_level", 32'(level_o), 32'd7);

    // Drain, then 40 pushes with the reader keeping pace.
    for (int i = 0; i < 4; i++) step(1'b0, wcount);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, wcount);
      if (i >= 2) begin
        chk("wrap_level", 32'(level_o), 32'd3);
        chk("wrap_full", 32'(full_o), 32'd0);
      end
    end

    // Random pushes and pops.
    for (int i = 0; i < 80; i++) begin
      int r;
      r = rcount;
      if (r < wcount && ($urandom % 2) == 1) r++;
      step(1'(($urandom % 3) != 0), r);
    end

    // Bring level to 5, then reset mid-cycle.
    for (int i = 0; i < 4; i++) step(1'b0, wcount);
    begin
      int base;
      base = wcount;
      for (int i = 0; i < 5; i++) step(1'b1, base);
    end
    chk("pre_rst_level", 32'(level_o), 32'd5);
    wr_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk_zero("midrst");
    model_reset();
    rptr_gray_i = '0;
    @(negedge clk);
    rst_i = 1'b0;
    step(1'b1, 0);
    chk("post_rst_gray", 32'(wptr_gray_o), 32'd1);
    step(1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
